systolic_load_sequencer: RTL and testbench
==========================================

// Module: systolic_load_sequencer
// PURPOSE
//  Sequences the two 3x3 systolicArray instances used by top_chip for a fixed 3x3 kernel, stride-1, valid convolution.
//  Loads weight rows once per output channel and input rows once per output pixel into both arrays.
//  Waits out the compute latency, then pulses final_out_en and reports the output coordinates.
//  Sits between the a/b/c input streams and the array row write enables; it replaces ad-hoc FSM sequencing.
// PARAMETERS
//  FEATURE_MAP_WIDTH   16  input map width; output width OW = FEATURE_MAP_WIDTH-2 (must be >= 3)
//  FEATURE_MAP_HEIGHT  16  input map height; output height OH = FEATURE_MAP_HEIGHT-2 (must be >= 3)
//  OUTPUT_NB_CHANNELS   4  number of output channels (kernels)
//  COMPUTE_LATENCY      2  cycles from the last input-row write until the array sum is stable (>= 1)
// PORTS
//  clk            in   1   clock
//  arst_n_in      in   1   asynchronous reset, active low
//  start          in   1   starts a run; sampled only in IDLE
//  running        out  1   high from the cycle after start is accepted until the return to IDLE
//  a_valid/b_valid/c_valid  in   1 each  row element 0/1/2 valid
//  a_ready/b_ready/c_ready  out  1 each  row element 0/1/2 ready
//  w_row_we_1     out  3   one-hot weight row write enable, array 1 (bit r = w r0_r1_r2)
//  i_row_we_1     out  3   one-hot input row write enable, array 1
//  w_row_we_2     out  3   weight row write enable, array 2
//  i_row_we_2     out  3   input row write enable, array 2
//  final_out_en   out  1   one-cycle pulse: out_1+out_2 is valid, register it
//  output_x       out  $clog2(FEATURE_MAP_WIDTH)   current output column
//  output_y       out  $clog2(FEATURE_MAP_HEIGHT)  current output row
//  output_ch      out  $clog2(OUTPUT_NB_CHANNELS)  current output channel
// BEHAVIOUR
//  Reset: state=IDLE, running=0, all readies=0, all we=0, final_out_en=0, x=y=ch=0, row=0, lat_cnt=0.
//  Handshake: in LOAD_* states, a_ready = b_valid & c_valid; b_ready = a_valid & c_valid; c_ready = a_valid & b_valid.
//   A row transfer (fire) = a_valid & b_valid & c_valid & in LOAD_*. No stream is consumed alone.
//   Readies are 0 outside LOAD_*.
//  Enables: the we bit for the current row is combinational = fire; the array captures on the same edge. At most one we bit is set per cycle.
//  FSM (row counter 0..2; it advances on fire; a fire with row==2 clears row and changes state):
//   IDLE    : start -> LOAD_W1 (x=y=ch=0). start is ignored in any other state.
//   LOAD_W1 : 3 rows -> LOAD_W2
//   LOAD_W2 : 3 rows -> LOAD_I1
//   LOAD_I1 : 3 rows -> LOAD_I2
//   LOAD_I2 : 3 rows -> COMPUTE (lat_cnt=0)
//   COMPUTE : lat_cnt++ each cycle; when lat_cnt==COMPUTE_LATENCY-1 -> EMIT
//   EMIT    : final_out_en=1 for exactly this cycle; output_x/y/ch hold the pixel coordinates.
//             Then coordinates advance with x innermost, then y, then ch:
//             x<OW-1: x++ -> LOAD_I1
//             else x=0; y<OH-1: y++ -> LOAD_I1
//             else y=0; ch<OUTPUT_NB_CHANNELS-1: ch++ -> LOAD_W1 (weights reload)
//             else ch=0 -> IDLE, running=0 next cycle
//  Coordinates change only on the EMIT exit edge and are stable from LOAD_I1 to EMIT.
//  Stalls: a deasserted valid holds the state and row indefinitely; no timeout.
//  Per pixel: 6 fires + COMPUTE_LATENCY + 1 cycles minimum. Each new channel adds 6 weight fires.
//  Reset mid-run aborts immediately to reset values; partial rows are discarded and there is no resume.
//  There is no abort input; start pulses during a run have no effect.
// STRUCTURE
//  systolic_pkg: typedef enum logic [2:0] seq_state_t {IDLE,LOAD_W1,LOAD_W2,LOAD_I1,LOAD_I2,COMPUTE,EMIT}; localparam ROWS=3.
//  Sub-module wrap_counter #(MAX): inc/clear/last; instantiated three times for x, y, ch.
//  Row and latency counters stay inline.
// TESTING
//  1 Reset with valids high -> all readies/we/final_out_en=0, running=0; after release, IDLE holds until start.
//  2 FM 5x5, CH=1, LAT=2, valids always high, start -> 9 final_out_en pulses with (x,y) in order (0,0),(1,0),(2,0),(0,1)..(2,2);
//    first pulse 16 cycles after start; running falls after the last pulse.
//  3 FM 4x4, CH=2 -> w_row_we_* rows 0,1,2 fire exactly twice each (at ch 0 and ch 1);
//    i_row_we_* fire 4 times per channel; output_ch=1 on pulses 5-8.
//  4 In LOAD_I1 hold c_valid=0 for 5 cycles with a/b valid -> a_ready=b_ready=0, no we, row unchanged;
//    then c_valid=1 -> i_row_we_1[row]=1 that cycle.
//  5 Assert arst_n_in low during LOAD_I2 row 1 -> next cycle all outputs at reset values;
//    a fresh start restarts from weight row 0 at (0,0,0).
//  6 Pulse start during COMPUTE and EMIT -> no state change and no coordinate reset.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic array load sequencer.
package systolic_pkg;

  localparam int ROWS = 3;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_W1,
    LOAD_W2,
    LOAD_I1,
    LOAD_I2,
    COMPUTE,
    EMIT
  } seq_state_t;

  // Counter width that never collapses to zero bits for single-entry ranges.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/systolic_load_sequencer_wrap_counter.sv
// Modulo-MAX counter used for the output x/y/channel coordinates.
module wrap_counter #(
  parameter int MAX = 4,
  parameter int W   = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clear,
  output logic [W-1:0] value,
  output logic         last
);

  assign last = (value == W'(MAX - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      value <= '0;
    else if (clear)  value <= '0;
    else if (inc)    value <= last ? '0 : value + 1'b1;
  end

endmodule

// File: rtl/systolic_load_sequencer.sv
// Feeds weight and input rows into the two 3x3 systolic arrays and signals
// when out_1+out_2 holds a finished output pixel.
module systolic_load_sequencer
  import systolic_pkg::*;
#(
  parameter int FEATURE_MAP_WIDTH  = 16,
  parameter int FEATURE_MAP_HEIGHT = 16,
  parameter int OUTPUT_NB_CHANNELS = 4,
  parameter int COMPUTE_LATENCY    = 2
) (
  input  logic                                    clk,
  input  logic                                    arst_n_in,
  input  logic                                    start,
  output logic                                    running,
  input  logic                                    a_valid,
  input  logic                                    b_valid,
  input  logic                                    c_valid,
  output logic                                    a_ready,
  output logic                                    b_ready,
  output logic                                    c_ready,
  output logic [ROWS-1:0]                         w_row_we_1,
  output logic [ROWS-1:0]                         i_row_we_1,
  output logic [ROWS-1:0]                         w_row_we_2,
  output logic [ROWS-1:0]                         i_row_we_2,
  output logic                                    final_out_en,
  output logic [cnt_w(FEATURE_MAP_WIDTH)-1:0]     output_x,
  output logic [cnt_w(FEATURE_MAP_HEIGHT)-1:0]    output_y,
  output logic [cnt_w(OUTPUT_NB_CHANNELS)-1:0]    output_ch
);

  localparam int OW = FEATURE_MAP_WIDTH - 2;
  localparam int OH = FEATURE_MAP_HEIGHT - 2;
  localparam int XW = cnt_w(FEATURE_MAP_WIDTH);
  localparam int YW = cnt_w(FEATURE_MAP_HEIGHT);
  localparam int CW = cnt_w(OUTPUT_NB_CHANNELS);
  localparam int LW = cnt_w(COMPUTE_LATENCY);

  seq_state_t      state;
  logic [1:0]      row;
  logic [LW-1:0]   lat_cnt;
  logic            in_load, fire, row_last, lat_done, emit;
  logic [ROWS-1:0] row_oh;
  logic            x_last, y_last, ch_last, coord_clr;

  assign in_load  = (state == LOAD_W1) || (state == LOAD_W2) ||
                    (state == LOAD_I1) || (state == LOAD_I2);
  assign fire     = in_load & a_valid & b_valid & c_valid;
  assign row_last = (row == 2'(ROWS - 1));
  assign lat_done = (lat_cnt == LW'(COMPUTE_LATENCY - 1));
  assign emit     = (state == EMIT);
  assign row_oh   = ROWS'(1) << row;

  // Each stream is ready only when the other two can join it, so a row moves as a unit.
  assign a_ready = in_load & b_valid & c_valid;
  assign b_ready = in_load & a_valid & c_valid;
  assign c_ready = in_load & a_valid & b_valid;

  assign w_row_we_1 = (fire && state == LOAD_W1) ? row_oh : '0;
  assign w_row_we_2 = (fire && state == LOAD_W2) ? row_oh : '0;
  assign i_row_we_1 = (fire && state == LOAD_I1) ? row_oh : '0;
  assign i_row_we_2 = (fire && state == LOAD_I2) ? row_oh : '0;

  assign final_out_en = emit;
  assign running      = (state != IDLE);
  assign coord_clr    = (state == IDLE) & start;

  wrap_counter #(.MAX(OW), .W(XW)) u_x (
    .clk(clk), .rst_n(arst_n_in), .inc(emit), .clear(coord_clr),
    .value(output_x), .last(x_last)
  );

  wrap_counter #(.MAX(OH), .W(YW)) u_y (
    .clk(clk), .rst_n(arst_n_in), .inc(emit & x_last), .clear(coord_clr),
    .value(output_y), .last(y_last)
  );

  wrap_counter #(.MAX(OUTPUT_NB_CHANNELS), .W(CW)) u_ch (
    .clk(clk), .rst_n(arst_n_in), .inc(emit & x_last & y_last), .clear(coord_clr),
    .value(output_ch), .last(ch_last)
  );

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      state   <= IDLE;
      row     <= '0;
      lat_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          row <= '0;
          if (start) state <= LOAD_W1;
        end
        LOAD_W1, LOAD_W2, LOAD_I1, LOAD_I2: begin
          if (fire) begin
            row <= row_last ? 2'd0 : row + 2'd1;
            if (row_last) begin
              case (state)
                LOAD_W1: state <= LOAD_W2;
                LOAD_W2: state <= LOAD_I1;
                LOAD_I1: state <= LOAD_I2;
                default: begin
                  state   <= COMPUTE;
                  lat_cnt <= '0;
                end
              endcase
            end
          end
        end
        COMPUTE: begin
          lat_cnt <= lat_cnt + 1'b1;
          if (lat_done) state <= EMIT;
        end
        EMIT: begin
          // Weights stay resident across a channel; only a channel change reloads them.
          if (!x_last || !y_last) state <= LOAD_I1;
          else if (!ch_last)      state <= LOAD_W1;
          else                    state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_load_sequencer.sv
// Scoreboard bench for systolic_load_sequencer: 5x5 map, 2 channels, latency 2.
module tb_systolic_load_sequencer;

  localparam int FMW = 5;
  localparam int FMH = 5;
  localparam int NCH = 2;
  localparam int LAT = 2;
  localparam int OW  = FMW - 2;
  localparam int OH  = FMH - 2;

  logic       clk = 1'b0;
  logic       arst_n_in, start, a_valid, b_valid, c_valid;
  logic       running, a_ready, b_ready, c_ready, final_out_en;
  logic [2:0] w_row_we_1, i_row_we_1, w_row_we_2, i_row_we_2;
  logic [2:0] output_x, output_y;
  logic [0:0] output_ch;
  logic [11:0] we_all;

  int n_vec = 0;
  int n_err = 0;
  int sb[$];
  int wc[4][3];
  bit prev_pulse = 1'b0;

  always #5 clk = ~clk;

  assign we_all = {i_row_we_2, w_row_we_2, i_row_we_1, w_row_we_1};

  systolic_load_sequencer #(
    .FEATURE_MAP_WIDTH(FMW), .FEATURE_MAP_HEIGHT(FMH),
    .OUTPUT_NB_CHANNELS(NCH), .COMPUTE_LATENCY(LAT)
  ) dut (
    .clk(clk), .arst_n_in(arst_n_in), .start(start), .running(running),
    .a_valid(a_valid), .b_valid(b_valid), .c_valid(c_valid),
    .a_ready(a_ready), .b_ready(b_ready), .c_ready(c_ready),
    .w_row_we_1(w_row_we_1), .i_row_we_1(i_row_we_1),
    .w_row_we_2(w_row_we_2), .i_row_we_2(i_row_we_2),
    .final_out_en(final_out_en),
    .output_x(output_x), .output_y(output_y), .output_ch(output_ch)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic int xyc();
    return int'(output_ch) * 256 + int'(output_y) * 16 + int'(output_x);
  endfunction

  task automatic push_run();
    for (int ch = 0; ch < NCH; ch++)
      for (int y = 0; y < OH; y++)
        for (int x = 0; x < OW; x++)
          sb.push_back(ch * 256 + y * 16 + x);
  endtask

  // start is high for one full cycle; returns in the first LOAD_W1 cycle.
  task automatic kick();
    @(posedge clk); #1 start = 1'b1;
    push_run();
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_we(input int sel, input int r, input string tag);
    int k;
    for (k = 0; k < 300; k++) begin
      @(negedge clk);
      if (we_all[sel*3+r]) break;
    end
    chk(tag, 32'(k < 300), 1);
  endtask

  task automatic run_to_end(input bit stall);
    int k;
    for (k = 0; k < 3000; k++) begin
      @(posedge clk); #1;
      if (stall) begin
        a_valid = ($urandom_range(0, 3) != 0);
        b_valid = ($urandom_range(0, 3) != 0);
        c_valid = ($urandom_range(0, 3) != 0);
      end else begin
        {a_valid, b_valid, c_valid} = 3'b111;
      end
      if (!running && sb.size() == 0) break;
    end
    chk("run_done", 32'(k < 3000), 1);
    {a_valid, b_valid, c_valid} = 3'b111;
  endtask

  // Monitor: pops the scoreboard on each pulse and tallies row enables.
  always @(negedge clk) begin
    if (arst_n_in) begin
      if (we_all != '0) begin
        chk("we_onehot", $countones(we_all), 1);
        chk("we_needs_fire", {a_valid, b_valid, c_valid}, 3'b111);
        for (int r = 0; r < 3; r++) begin
          wc[0][r] += int'(w_row_we_1[r]);
          wc[1][r] += int'(i_row_we_1[r]);
          wc[2][r] += int'(w_row_we_2[r]);
          wc[3][r] += int'(i_row_we_2[r]);
        end
      end
      if (final_out_en) begin
        chk("pulse_running", running, 1);
        if (sb.size() == 0) chk("pulse_unexpected", 1, 0);
        else chk("pulse_xyc", xyc(), sb.pop_front());
      end else if (prev_pulse && sb.size() == 0) begin
        chk("running_fall", running, 0);
      end
      prev_pulse = final_out_en;
    end else begin
      prev_pulse = 1'b0;
    end
  end

  initial begin
    int cyc, k;
    arst_n_in = 1'b0;
    start     = 1'b0;
    {a_valid, b_valid, c_valid} = 3'b111;

    // Reset with valids high, then idle without start.
    #12;
    chk("rst_outs", {a_ready, b_ready, c_ready, we_all, final_out_en, running}, 0);
    chk("rst_xyc", xyc(), 0);
    @(posedge clk); #1 arst_n_in = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("idle_hold", {running, a_ready, b_ready, c_ready, we_all}, 0);
    end

    // Run A: valids always high; first pulse lands in the 16th cycle counting the start cycle as 1.
    wc = '{default: 0};
    kick();
    cyc = 2;
    for (k = 0; k < 100; k++) begin
      @(negedge clk);
      if (final_out_en) break;
      @(posedge clk);
      cyc++;
    end
    chk("first_pulse_cyc", cyc, 4 * 3 + LAT + 2);
    run_to_end(1'b0);
    for (int r = 0; r < 3; r++) begin
      chk("w1_row_count", wc[0][r], NCH);
      chk("w2_row_count", wc[2][r], NCH);
      chk("i1_row_count", wc[1][r], OW * OH * NCH);
      chk("i2_row_count", wc[3][r], OW * OH * NCH);
    end
    chk("sb_empty_a", sb.size(), 0);

    // Run B: stall on c in LOAD_I1 row 1, then start pulses during COMPUTE/EMIT.
    kick();
    wait_we(1, 0, "reach_i1");
    @(posedge clk); #1 c_valid = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("stall_rdy", {a_ready, b_ready, c_ready}, 3'b001);
      chk("stall_we", we_all, 0);
    end
    @(posedge clk); #1 c_valid = 1'b1;
    @(negedge clk);
    chk("stall_resume", i_row_we_1, 3'b010);
    wait_we(3, 2, "reach_i2_last");
    @(posedge clk); #1 start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("start_ignored_run", running, 1);
      chk("emit_timing", final_out_en, 32'(i == 2));
      @(posedge clk);
    end
    #1 start = 1'b0;
    @(negedge clk);
    chk("no_restart", i_row_we_1, 3'b001);
    chk("coord_kept", xyc(), 1);
    run_to_end(1'b1);
    chk("sb_empty_b", sb.size(), 0);

    // Run C: reset during LOAD_I2 row 1, then a clean restart.
    kick();
    wait_we(3, 1, "reach_i2_row1");
    arst_n_in = 1'b0;
    #1;
    chk("abort_outs", {a_ready, b_ready, c_ready, we_all, final_out_en, running}, 0);
    chk("abort_xyc", xyc(), 0);
    sb.delete();
    @(negedge clk);
    chk("abort_hold", {a_ready, b_ready, c_ready, we_all, final_out_en, running}, 0);
    @(posedge clk); #1 arst_n_in = 1'b1;
    kick();
    @(negedge clk);
    chk("restart_w_row0", w_row_we_1, 3'b001);
    chk("restart_xyc", xyc(), 0);
    run_to_end(1'b1);
    chk("sb_empty_c", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
